// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN execution controller: FSM states, default
// vector length and the bfloat16 zero pattern.
package dnn_pkg;

  localparam int F_SIZE_DEF = 512;
  localparam logic [15:0] BF16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_NORM,
    ST_CAPT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/fp32_to_bf16.sv
// Combinational fp32 -> bfloat16 narrowing with round-to-nearest-even.
module fp32_to_bf16 (
  input  logic [31:0] fp32,
  output logic [15:0] bf16
);

  logic round_up;

  // Halfway cases round toward the even upper half; a mantissa carry ripples
  // into the exponent through the plain 16-bit add.
  assign round_up = fp32[15] & (fp32[16] | (fp32[14:0] != 15'd0));
  assign bf16     = fp32[31:16] + {15'd0, round_up};

endmodule

// File: rtl/dnn_exec_ctrl.sv
// Sequences one dot-product job: streams activations into an external MAC
// core, waits for it to drain, normalizes, and returns a bfloat16 result.
module dnn_exec_ctrl
  import dnn_pkg::*;
#(
  parameter int F_SIZE = F_SIZE_DEF,
  parameter bit RELU   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  cfg_len,
  output logic        cfg_err,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        core_init,
  output logic        core_exec,
  output logic [8:0]  core_a,
  output logic [15:0] core_d,
  input  logic        core_busy,
  output logic        norm_en,
  input  logic [31:0] nrm,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        idle
);

  localparam logic [10:0] MAX_LEN = 11'(F_SIZE);

  state_t      state, state_n;
  logic [8:0]  cnt;
  logic [9:0]  len;
  logic [15:0] res_q;
  logic        cfg_err_q;
  logic [15:0] conv;
  logic        len_ok;
  logic        accept;
  logic        last;

  fp32_to_bf16 u_round (
    .fp32 (nrm),
    .bf16 (conv)
  );

  assign len_ok = (cfg_len != 10'd0) && ({1'b0, cfg_len} <= MAX_LEN);
  assign accept = (state == ST_RUN) && s_valid;
  assign last   = (({1'b0, cnt} + 10'd1) == len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The counter stops at the final accept so it never passes len-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 9'd0;
      len       <= 10'd0;
      res_q     <= BF16_ZERO;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == ST_IDLE) && start && !len_ok;
      if ((state == ST_IDLE) && start && len_ok) begin
        len <= cfg_len;
      end
      if (state == ST_INIT) begin
        cnt <= 9'd0;
      end else if (accept && !last) begin
        cnt <= cnt + 9'd1;
      end
      if (state == ST_CAPT) begin
        res_q <= (RELU && conv[15]) ? BF16_ZERO : conv;
      end
    end
  end

  always_comb begin
    state_n   = state;
    core_init = 1'b0;
    core_exec = 1'b0;
    core_a    = 9'd0;
    core_d    = 16'd0;
    s_ready   = 1'b0;
    norm_en   = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && len_ok) state_n = ST_INIT;
      end
      ST_INIT: begin
        core_init = 1'b1;
        state_n   = ST_RUN;
      end
      ST_RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          core_exec = 1'b1;
          core_a    = cnt;
          core_d    = s_data;
          if (last) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!core_busy) state_n = ST_NORM;
      end
      ST_NORM: begin
        norm_en = 1'b1;
        state_n = ST_CAPT;
      end
      ST_CAPT: begin
        state_n = ST_OUT;
      end
      ST_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign cfg_err  = cfg_err_q;
  assign res_data = res_q;
  assign idle     = (state == ST_IDLE);

endmodule

// File: tb/tb_dnn_exec_ctrl.sv
// Directed bench: two controllers (RELU off/on) share one stimulus, each with
// its own behavioural MAC core and normalizer; plus a standalone rounder.
module tb_dnn_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  cfg_len;
  logic        s_valid;
  logic [15:0] s_data;
  logic        res_ready;

  logic        cfg_err_v   [2];
  logic        s_ready_v   [2];
  logic        core_init_v [2];
  logic        core_exec_v [2];
  logic [8:0]  core_a_v    [2];
  logic [15:0] core_d_v    [2];
  logic        core_busy_v [2];
  logic        norm_en_v   [2];
  logic [31:0] nrm_v       [2];
  logic        res_valid_v [2];
  logic [15:0] res_data_v  [2];
  logic        idle_v      [2];

  logic [31:0] cv_in;
  logic [15:0] cv_out;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] WEIGHT = 16'h3F80;

  always #5 clk = ~clk;

  function automatic real bf2real(input logic [15:0] b);
    logic [63:0] d;
    if (b[14:7] == 8'd0) return 0.0;
    d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2fp32(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // The MAC model keeps its accumulator across resets on purpose, so only
  // core_init can clear what an earlier job left behind.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    real acc = 0.0;
    logic busy_q;

    dnn_exec_ctrl #(.F_SIZE(512), .RELU(g == 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_len   (cfg_len),
      .cfg_err   (cfg_err_v[g]),
      .s_valid   (s_valid),
      .s_ready   (s_ready_v[g]),
      .s_data    (s_data),
      .core_init (core_init_v[g]),
      .core_exec (core_exec_v[g]),
      .core_a    (core_a_v[g]),
      .core_d    (core_d_v[g]),
      .core_busy (core_busy_v[g]),
      .norm_en   (norm_en_v[g]),
      .nrm       (nrm_v[g]),
      .res_valid (res_valid_v[g]),
      .res_ready (res_ready),
      .res_data  (res_data_v[g]),
      .idle      (idle_v[g])
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= 1'b0;
      else        busy_q <= core_exec_v[g];
    end

    always @(posedge clk) begin
      if (core_init_v[g])      acc <= 0.0;
      else if (core_exec_v[g]) acc <= acc + bf2real(core_d_v[g]) * bf2real(WEIGHT);
      if (norm_en_v[g])        nrm_v[g] <= real2fp32(acc);
    end

    assign core_busy_v[g] = busy_q;
  end

  fp32_to_bf16 u_cv (
    .fp32 (cv_in),
    .bf16 (cv_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge and outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic st, input logic [9:0] len,
                               input logic sv, input logic [15:0] sd, input logic rr);
    @(negedge clk);
    start     = st;
    cfg_len   = len;
    s_valid   = sv;
    s_data    = sd;
    res_ready = rr;
    #1;
  endtask

  task automatic runJob(input string tag, input logic [9:0] len,
                        input logic [15:0] data, input bit gaps);
    int accepted = 0;
    int execs    = 0;
    int cyc      = 0;
    int lat      = 0;
    int norm_at  = -1;
    logic sv;
    applyStimulus(1'b1, len, 1'b0, 16'h0, 1'b0);
    checkOutput({tag, "_idle_at_start"}, idle_v[0], 1);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput({tag, "_init"}, {core_init_v[0], s_ready_v[0], idle_v[0]}, 3'b100);
    while (accepted < int'(len) && cyc < 2000) begin
      sv = gaps ? (cyc % 2 == 1) : 1'b1;
      applyStimulus(1'b0, 10'd0, sv, data, 1'b0);
      cyc++;
      if (core_exec_v[0]) execs++;
      if (sv) begin
        checkOutput({tag, "_core_a"}, {core_exec_v[0], s_ready_v[0], 7'd0, core_a_v[0]},
                    {2'b11, 7'd0, 9'(accepted)});
        checkOutput({tag, "_core_d"}, core_d_v[0], data);
        accepted++;
      end else begin
        checkOutput({tag, "_gap"}, {core_exec_v[0], s_ready_v[0], 7'd0, core_a_v[0], core_d_v[0]},
                    {2'b01, 32'd0});
      end
    end
    while (!res_valid_v[0] && lat < 50) begin
      applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
      lat++;
      if (core_exec_v[0]) execs++;
      if (norm_en_v[0] && norm_at < 0) norm_at = lat;
      if (lat == 1) checkOutput({tag, "_drain_ready"}, s_ready_v[0], 0);
    end
    checkOutput({tag, "_exec_count"}, execs, int'(len));
    checkOutput({tag, "_norm_at"}, norm_at, 3);
    checkOutput({tag, "_res_latency"}, lat, 5);
  endtask

  task automatic finishResult(input string tag);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b1);
    checkOutput({tag, "_valid_at_hs"}, res_valid_v[0], 1);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput({tag, "_back_idle"}, {idle_v[0], res_valid_v[0]}, 2'b10);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_len = 10'd0; s_valid = 1'b0;
    s_data = 16'h0; res_ready = 1'b0; cv_in = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                {idle_v[0], cfg_err_v[0], s_ready_v[0], core_init_v[0], core_exec_v[0],
                 norm_en_v[0], res_valid_v[0]}, 7'b1000000);
    checkOutput("reset_res_data", res_data_v[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] back-to-back job, len=4");
    runJob("b2b", 10'd4, 16'h3F80, 1'b0);
    checkOutput("b2b_res", res_data_v[0], 16'h4080);
    checkOutput("b2b_res_relu", res_data_v[1], 16'h4080);
    finishResult("b2b");

    $display("[TB] job with input gaps, len=4");
    runJob("gap", 10'd4, 16'h3F80, 1'b1);
    checkOutput("gap_res", res_data_v[0], 16'h4080);
    finishResult("gap");

    $display("[TB] illegal lengths");
    applyStimulus(1'b1, 10'd0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput("len0_err", {cfg_err_v[0], core_init_v[0], idle_v[0]}, 3'b101);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput("len0_pulse_end", {cfg_err_v[0], core_init_v[0], idle_v[0]}, 3'b001);
    applyStimulus(1'b1, 10'd513, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput("len513_err", {cfg_err_v[0], core_init_v[0], idle_v[0]}, 3'b101);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput("len513_pulse_end", {cfg_err_v[0], core_init_v[0], idle_v[0]}, 3'b001);

    $display("[TB] maximum length job, len=512");
    runJob("max", 10'd512, 16'h3F80, 1'b0);
    checkOutput("max_res", res_data_v[0], 16'h4400);
    finishResult("max");

    $display("[TB] negative result, RELU off/on, with held res_ready");
    runJob("neg", 10'd1, 16'hC000, 1'b0);
    checkOutput("neg_res_norelu", res_data_v[0], 16'hC000);
    checkOutput("neg_res_relu", res_data_v[1], 16'h0000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i == 3) || (i == 5), (i == 5) ? 10'd0 : 10'd1, 1'b0, 16'h0, 1'b0);
      checkOutput("hold_stable", {res_valid_v[0], cfg_err_v[0], core_init_v[0], res_data_v[0]},
                  {3'b100, 16'hC000});
    end
    finishResult("neg");
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    checkOutput("start_in_out_ignored", {core_init_v[0], idle_v[0]}, 2'b01);

    $display("[TB] reset during RUN");
    applyStimulus(1'b1, 10'd4, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b1, 16'h4000, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b1, 16'h4000, 1'b0);
    applyStimulus(1'b0, 10'd0, 1'b1, 16'h4000, 1'b0);
    checkOutput("abort_core_a", core_a_v[0], 9'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_async", {idle_v[0], s_ready_v[0], core_exec_v[0], res_data_v[0]},
                {3'b100, 16'h0000});
    applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 10'd0, 1'b0, 16'h0, 1'b0);
      checkOutput("abort_no_result", {res_valid_v[0], idle_v[0]}, 2'b01);
    end
    runJob("after_rst", 10'd1, 16'h4000, 1'b0);
    checkOutput("after_rst_res", res_data_v[0], 16'h4000);
    finishResult("after_rst");

    $display("[TB] standalone rounding vectors");
    cv_in = 32'h3F808000; #1; checkOutput("cv_tie_even", cv_out, 16'h3F80);
    cv_in = 32'h3F818000; #1; checkOutput("cv_tie_odd", cv_out, 16'h3F82);
    cv_in = 32'h3F80C000; #1; checkOutput("cv_above_half", cv_out, 16'h3F81);
    cv_in = 32'h3F807FFF; #1; checkOutput("cv_below_half", cv_out, 16'h3F80);
    cv_in = 32'h3FFF8000; #1; checkOutput("cv_carry_exp", cv_out, 16'h4000);
    cv_in = 32'h00000000; #1; checkOutput("cv_zero", cv_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
